// File: rtl/rng_buf.sv
// RNG output buffer: repetition-count health test in front of a small FIFO,
// served to the core over a request/valid read port. A tripped test flushes and locks output.
module rng_buf #(
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              rand_num_i,
  input  logic                     rand_num_valid_i,
  input  logic                     rd_req_i,
  input  logic                     clear_i,
  output logic [63:0]              rd_data_o,
  output logic                     rd_valid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     health_fail_o,
  output logic                     fsm_state
);

  // Handshake: rand_num_valid_i is a push with no backpressure (a word that
  // finds the FIFO full is dropped); rd_req_i is accepted only in a cycle
  // where the FIFO is non-empty, and each accepted request produces exactly
  // one rd_valid_o pulse on the following cycle. Requests to an empty FIFO
  // are not remembered.

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (REP_LIMIT > 2) ? $clog2(REP_LIMIT) : 1;
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT - 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    FAIL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_q;
  logic [RW-1:0]   rep_cnt;
  logic            hist_v;
  logic [63:0]     last_word;

  logic            running;
  logic            repeat_word;
  logic            trip;
  logic            do_wr;
  logic            do_rd;

  assign running     = (state_q == RUN) && !clear_i;
  assign repeat_word = hist_v && (rand_num_i == last_word);
  // The REP_LIMIT-th identical word in a row: rep_cnt already counts REP_LIMIT-2 repeats.
  assign trip        = running && rand_num_valid_i && repeat_word && (rep_cnt == REP_MAX);
  assign do_wr       = running && rand_num_valid_i && !trip && (count_q != FULL_CNT);
  assign do_rd       = running && rd_req_i && !trip && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (trip) state_d = FAIL;
      FAIL:    state_d = FAIL;
      default: state_d = RUN;
    endcase
    if (clear_i) state_d = RUN;
  end

  // Storage array carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rand_num_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= do_rd;
      if (do_rd) begin
        rd_data_o <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (trip) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      hist_v    <= 1'b0;
      last_word <= '0;
    end else if (clear_i) begin
      rep_cnt <= '0;
      hist_v  <= 1'b0;
    end else if (running && rand_num_valid_i && !trip) begin
      rep_cnt   <= repeat_word ? rep_cnt + 1'b1 : '0;
      last_word <= rand_num_i;
      hist_v    <= 1'b1;
    end
  end

  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == FULL_CNT);
  assign health_fail_o = (state_q == FAIL);
  assign fsm_state     = state_q;

endmodule
